lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store initiator between the core's MEM stage and the word-wide data memory.
//  - Turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) on byte addresses into word accesses.
//  - Extracts and extends load data; merges sub-word stores by read-modify-write.
//  - Flags misaligned, illegal or out-of-range requests.
//  - Data memory: combinational read when r_en=1, word write on posedge clk when w_en=1.
// PARAMETERS
//  MEM_WIDTH  32    data word width
//  MEM_DEPTH  1024  memory depth in words; word indices >= MEM_DEPTH are out of range
//  ADDR_SIZE  32    width of req_addr and mem_addr
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous, active-low reset
//  req_valid    in   1          request present
//  req_ready    out  1          unit accepts a request this cycle
//  req_we       in   1          1=store, 0=load
//  req_funct3   in   3          RV32I funct3 (size/sign)
//  req_addr     in   ADDR_SIZE  byte address
//  req_wdata    in   MEM_WIDTH  store data (low bytes used for SB/SH)
//  rsp_valid    out  1          one-cycle response pulse
//  rsp_rdata    out  MEM_WIDTH  extended load data; 0 for stores and errors
//  rsp_err      out  1          misaligned/illegal/out-of-range; valid with rsp_valid
//  mem_addr     out  ADDR_SIZE  word index = req_addr >> 2
//  mem_r_en     out  1          memory read enable
//  mem_w_en     out  1          memory write enable
//  mem_wdata    out  MEM_WIDTH  memory write data
//  mem_rdata    in   MEM_WIDTH  memory read data (combinational)
// BEHAVIOUR
//  Reset: rst low at posedge -> state IDLE; rsp_valid, rsp_err, rsp_rdata, latched regs = 0.
//  - While rst=0: req_ready, mem_r_en, mem_w_en = 0 (gated combinationally by rst).
//  - Mid-operation reset aborts the access; no write is issued in or after the reset cycle.
//  Handshake: req_ready = rst & (state==IDLE). Accept on req_valid & req_ready.
//  - Capture we, funct3, addr and wdata on accept. Requests while busy are not accepted.
//  FSM: IDLE, LOAD, RMW_RD, WRITE, RESP.
//  - Accept, error -> RESP with rsp_err=1. No memory access.
//  - Accept, load -> LOAD.
//  - Accept, SW -> WRITE.
//  - Accept, SB/SH -> RMW_RD.
//  - LOAD: mem_r_en=1. Register the extracted word into rsp_rdata. -> RESP.
//  - RMW_RD: mem_r_en=1. Register mem_rdata with the new lane(s) overwritten. -> WRITE.
//  - WRITE: mem_w_en=1, mem_wdata=SW data or merged word. -> RESP.
//  - RESP: rsp_valid=1 for exactly one cycle. -> IDLE.
//  Latency from accept edge to rsp_valid high:
//  - Error: 1 cycle. Load: 2 cycles. SW: 2 cycles. SB/SH: 3 cycles.
//  - Back-to-back throughput is 1 request per latency+1 cycles.
//  Errors:
//  - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
//  - Illegal funct3: loads 3, 6, 7; stores >2.
//  - Out-of-range: addr[ADDR_SIZE-1:2] >= MEM_DEPTH.
//  Lanes (little-endian): byte lane = addr[1:0], half lane = addr[1].
//  - LB/LH sign-extend; LBU/LHU zero-extend.
//  - SB writes byte k = wdata[7:0]; SH writes half = wdata[15:0]; other bytes keep mem_rdata.
//  Idle outputs: mem_addr = latched word index; mem_wdata = 0 except in WRITE.
//  rsp_rdata holds its value until the next response.
// STRUCTURE
//  Shared package (riscv_pkg):
//  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
//  - LSU state encoding.
//  Sub-module lsu_lane_align: combinational load extract/extend and store merge,
//  keyed by funct3 and addr[1:0].
//  Top holds the FSM, request latches and response registers.
// TESTING (bench pairs with data_mem, MEM_DEPTH=1024)
//  1. SW addr 0x10 data 0xDEADBEEF; then LW 0x10
//     -> each rsp_valid 2 cycles after accept; rdata=0xDEADBEEF, err=0.
//  2. After 1: LB 0x13 -> 0xFFFFFFDE. LBU 0x13 -> 0x000000DE.
//     LH 0x12 -> 0xFFFFDEAD. LHU 0x10 -> 0x0000BEEF.
//  3. After 1: SB 0x11 data 0x55 (3-cycle latency), then LW 0x10 -> 0xDEAD55EF.
//     SH 0x12 data 0x1234 -> word reads 0x123455EF.
//  4. LW 0x11, SH 0x13, LB funct3=3, SW 0x1000
//     -> rsp_err=1 after 1 cycle, rsp_rdata=0, mem_w_en never high.
//  5. Hold req_valid during an SB: req_ready=0 until RESP -> IDLE; the second request
//     is accepted only then and completes correctly.
//  6. Drop rst during WRITE of SW 0x20 data 0x1
//     -> no w_en in that cycle, state IDLE, rsp_valid never pulses,
//        next LW 0x20 -> 0x00000000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 size codes, LSU state encoding and alignment rule.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRmwRd,
    StWrite,
    StResp
  } lsu_state_e;

  // Access size comes from funct3[1:0]; only legal encodings need a meaningful answer.
  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'd1:    return addr_lo[0];
      2'd2:    return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge into a read word.
module lsu_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data_o = {24'h0, byte_sel};
      F3_HU:   load_data_o = {16'h0, half_sel};
      default: load_data_o = rdata_i;
    endcase

    store_data_o = rdata_i;
    case (funct3_i)
      F3_B: store_data_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H: begin
        if (addr_lo_i[1]) store_data_o[31:16] = wdata_i[15:0];
        else              store_data_o[15:0]  = wdata_i[15:0];
      end
      default: store_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: accepts one MEM-stage request at a time and drives a word-wide memory.
module lsu_mem_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MemWidth = 32,
  parameter int unsigned MemDepth = 1024,
  parameter int unsigned AddrSize = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [2:0]          req_funct3_i,
  input  logic [AddrSize-1:0] req_addr_i,
  input  logic [MemWidth-1:0] req_wdata_i,
  output logic                rsp_valid_o,
  output logic [MemWidth-1:0] rsp_rdata_o,
  output logic                rsp_err_o,
  output logic [AddrSize-1:0] mem_addr_o,
  output logic                mem_r_en_o,
  output logic                mem_w_en_o,
  output logic [MemWidth-1:0] mem_wdata_o,
  input  logic [MemWidth-1:0] mem_rdata_i
);

  lsu_state_e          state_q;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [AddrSize-1:0] addr_q;
  logic [MemWidth-1:0] wdata_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [MemWidth-1:0] rsp_rdata_q;

  logic [AddrSize-1:0] req_word;
  logic                illegal, misaligned, out_of_range, req_err;
  logic [MemWidth-1:0] load_data, store_data;

  assign req_word     = req_addr_i >> 2;
  assign illegal      = req_we_i ? (req_funct3_i > F3_W)
                                 : (req_funct3_i == 3'd3 || req_funct3_i >= 3'd6);
  assign misaligned   = lsu_misaligned(req_funct3_i, req_addr_i[1:0]);
  assign out_of_range = req_word >= AddrSize'(MemDepth);
  assign req_err      = illegal | misaligned | out_of_range;

  lsu_lane_align u_lane_align (
    .funct3_i     (funct3_q),
    .addr_lo_i    (addr_q[1:0]),
    .rdata_i      (mem_rdata_i),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_data_o (store_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            if (req_err) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (!req_we_i) begin
              state_q <= StLoad;
            end else if (req_funct3_i == F3_W) begin
              state_q <= StWrite;
            end else begin
              state_q <= StRmwRd;
            end
          end
        end
        StLoad: begin
          rsp_rdata_q <= load_data;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        // The merged word replaces the store data so WRITE drives one source.
        StRmwRd: begin
          wdata_q <= store_data;
          state_q <= StWrite;
        end
        StWrite: begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          rsp_err_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = rst & (state_q == StIdle);
  assign mem_r_en_o  = rst & ((state_q == StLoad) | (state_q == StRmwRd));
  assign mem_w_en_o  = rst & (state_q == StWrite);
  assign mem_wdata_o = (state_q == StWrite) ? wdata_q : '0;
  assign mem_addr_o  = addr_q >> 2;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule
